// File: rtl/egress_pkt_rx_pkg.sv
//------------------------------------------------------------------------------
// Module : egress_pkt_rx_pkg
// Brief  : Shared FSM states, header field layout and counter helpers.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package egress_pkt_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HDR   = 2'd1,
        ST_BODY  = 2'd2,
        ST_DRAIN = 2'd3
    } rx_state_t;

    localparam int c_DST_LSB = 0;
    localparam int c_DST_W   = 4;
    localparam int c_PRI_LSB = 4;
    localparam int c_PRI_W   = 3;
    localparam int c_LEN_LSB = 7;
    localparam int c_LEN_W   = 8;
    localparam int c_CNT_W   = 16;

    // Saturating add used by the statistics counters.
    function automatic logic [c_CNT_W-1:0] sat_add(input logic [c_CNT_W-1:0] a,
                                                   input logic [1:0]         inc);
        logic [c_CNT_W:0] w_sum;
        w_sum = {1'b0, a} + {{(c_CNT_W-1){1'b0}}, inc};
        return w_sum[c_CNT_W] ? '1 : w_sum[c_CNT_W-1:0];
    endfunction

endpackage

`default_nettype wire

// File: rtl/egress_beat_fifo.sv
//------------------------------------------------------------------------------
// Module : egress_beat_fifo
// Brief  : First-word-fall-through beat buffer with full/empty/free-count.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module egress_beat_fifo #(
    parameter int WIDTH = 65,
    parameter int DEPTH = 32
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_push,
    input  logic [WIDTH-1:0]       i_data,
    input  logic                   i_pop,
    output logic [WIDTH-1:0]       o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_free
);

    localparam int              c_AW    = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_DEPTH = DEPTH[c_AW:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_wr;
    logic             w_rd;

    assign o_empty = (r_count == '0);
    assign o_full  = (r_count == c_DEPTH);
    assign o_free  = c_DEPTH - r_count;

    // A pop in the same cycle frees the slot the push needs.
    assign w_wr = i_push && (!o_full || i_pop);
    assign w_rd = i_pop && !o_empty;

    assign o_data = o_empty ? '0 : r_mem[r_rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

`default_nettype wire

// File: rtl/egress_pkt_rx.sv
//------------------------------------------------------------------------------
// Module : egress_pkt_rx
// Brief  : Switch egress packet receiver: header checks, beat buffering, stats.
//          Macro EGRESS_RX_CHECK_EN enables header destination/length checks.
// Rev    : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module egress_pkt_rx
    import egress_pkt_rx_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int PORT_ID    = 0,
    parameter int FIFO_DEPTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rd_sop,
    input  logic                  rd_eop,
    input  logic                  rd_vld,
    input  logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ready,
    output logic                  out_vld,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    input  logic                  out_rdy,
    output logic [c_CNT_W-1:0]    pkt_cnt,
    output logic [c_CNT_W-1:0]    err_cnt,
    output logic                  err_dst,
    output logic                  err_len,
    output logic                  ovf
);

    localparam int c_FW = $clog2(FIFO_DEPTH) + 1;

    // Unsupported parameter sets show up as this scope in the elaborated tree.
    if (PORT_ID > 15 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_params
    end

    rx_state_t          r_state;
    rx_state_t          w_state_nxt;
    logic               w_in_pkt;
    logic               w_abort;
    logic               w_beat;
    logic               w_stray;
    logic               w_push;
    logic               w_pop;
    logic               w_drop;
    logic               w_full;
    logic               w_empty;
    logic [c_FW-1:0]    w_free;
    logic [c_FW-1:0]    w_free_nxt;
    logic               w_dst_err;
    logic               w_len_err;
    logic               w_len_flag;
    logic [1:0]         w_err_inc;
    logic               r_ready;
    logic [c_CNT_W-1:0] r_pkt_cnt;
    logic [c_CNT_W-1:0] r_err_cnt;
    logic               r_err_dst;
    logic               r_err_len;
    logic               r_ovf;

    assign w_in_pkt = (r_state == ST_HDR) || (r_state == ST_BODY);
    assign w_abort  = rd_sop && w_in_pkt;
    assign w_beat   = rd_vld && w_in_pkt && !rd_sop;
    assign w_stray  = rd_vld && !w_in_pkt;
    assign w_pop    = out_vld && out_rdy;
    assign w_push   = w_beat && (!w_full || w_pop);
    assign w_drop   = w_beat && !w_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (rd_sop) w_state_nxt = ST_HDR;
            ST_HDR: begin
                if (rd_sop)      w_state_nxt = ST_HDR;
                else if (rd_vld) w_state_nxt = rd_eop ? ST_DRAIN : ST_BODY;
            end
            ST_BODY: begin
                if (rd_sop)                w_state_nxt = ST_HDR;
                else if (rd_vld && rd_eop) w_state_nxt = ST_DRAIN;
            end
            // A sop landing right after eop starts the next packet instead of being lost.
            ST_DRAIN: w_state_nxt = rd_sop ? ST_HDR : ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

`ifdef EGRESS_RX_CHECK_EN
    localparam logic [c_DST_W-1:0] c_PORT_ID = c_DST_W'(PORT_ID);

    logic               w_hdr_beat;
    logic [c_DST_W-1:0] w_hdr_dst;
    logic [c_LEN_W-1:0] w_hdr_len;
    logic [c_LEN_W-1:0] r_len;
    logic [c_LEN_W:0]   r_beat_cnt;
    logic [c_LEN_W:0]   w_cnt_inc;

    assign w_hdr_beat = w_beat && (r_state == ST_HDR);
    assign w_hdr_dst  = rd_data[c_DST_LSB +: c_DST_W];
    assign w_hdr_len  = rd_data[c_LEN_LSB +: c_LEN_W];
    assign w_cnt_inc  = (&r_beat_cnt) ? r_beat_cnt : r_beat_cnt + 1'b1;

    // Dropped payload beats still count so overflow does not look like a length error.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else if (w_hdr_beat) begin
            r_len      <= w_hdr_len;
            r_beat_cnt <= '0;
        end else if (w_beat) begin
            r_beat_cnt <= w_cnt_inc;
        end
    end

    assign w_dst_err  = w_hdr_beat && (w_hdr_dst != c_PORT_ID);
    assign w_len_err  = w_beat && rd_eop &&
                        ((r_state == ST_HDR) ? (w_hdr_len != '0)
                                             : (w_cnt_inc != {1'b0, r_len}));
    assign w_len_flag = w_len_err || w_abort;
`else
    assign w_dst_err  = 1'b0;
    assign w_len_err  = 1'b0;
    assign w_len_flag = 1'b0;
`endif

    assign w_err_inc = 2'(w_abort) + 2'(w_drop) + 2'(w_stray)
                     + 2'(w_dst_err) + 2'(w_len_err);

    assign w_free_nxt = w_free + c_FW'(w_pop) - c_FW'(w_push);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ready   <= 1'b0;
            r_pkt_cnt <= '0;
            r_err_cnt <= '0;
            r_err_dst <= 1'b0;
            r_err_len <= 1'b0;
            r_ovf     <= 1'b0;
        end else begin
            r_ready   <= (w_free_nxt >= c_FW'(2));
            r_pkt_cnt <= (w_push && rd_eop) ? sat_add(r_pkt_cnt, 2'd1) : r_pkt_cnt;
            r_err_cnt <= sat_add(r_err_cnt, w_err_inc);
            if (w_dst_err)  r_err_dst <= 1'b1;
            if (w_len_flag) r_err_len <= 1'b1;
            if (w_drop)     r_ovf     <= 1'b1;
        end
    end

    egress_beat_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst),
        .i_push  (w_push),
        .i_data  ({rd_eop, rd_data}),
        .i_pop   (w_pop),
        .o_data  ({out_last, out_data}),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_free  (w_free)
    );

    assign out_vld = !w_empty;
    assign ready   = r_ready;
    assign pkt_cnt = r_pkt_cnt;
    assign err_cnt = r_err_cnt;
    assign err_dst = r_err_dst;
    assign err_len = r_err_len;
    assign ovf     = r_ovf;

endmodule

`default_nettype wire
